// File: rtl/trap_ctrl.sv
// trap_ctrl: pipeline stall merge, machine-mode trap arbitration and redirect.
// A detected trap or mret waits in DRAIN until the pipeline stops stalling.
// It then issues one flush cycle, with the CSR strobes and the redirect PC.
module trap_ctrl #(
  parameter int              XLEN        = 32,
  parameter int              NUM_STAGES  = 6,
  parameter int              NUM_LIRQ    = 4,
  parameter logic [XLEN-1:0] REBOOT_ADDR = 32'h0000_0000
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NUM_STAGES-1:0] stallreq_i,
  input  logic [6:0]            exception_i,
  input  logic [XLEN-1:0]       pc_i,
  input  logic [31:0]           ins_i,
  input  logic [XLEN-1:0]       badaddr_i,
  input  logic                  mstatus_mie_i,
  input  logic [16+NUM_LIRQ-1:0] irq_en_i,
  input  logic [16+NUM_LIRQ-1:0] irq_pend_i,
  input  logic [XLEN-1:0]       mtvec_i,
  input  logic [XLEN-1:0]       mepc_i,
  output logic [NUM_STAGES-1:0] stall_o,
  output logic                  flush_o,
  output logic [XLEN-1:0]       new_pc_o,
  output logic                  set_cause_o,
  output logic                  set_epc_o,
  output logic                  set_mtval_o,
  output logic [XLEN-1:0]       cause_o,
  output logic [XLEN-1:0]       epc_o,
  output logic [XLEN-1:0]       mtval_o,
  output logic                  mie_clear_o,
  output logic                  mie_set_o,
  output logic                  busy_o
);

  localparam int NIRQ = 16 + NUM_LIRQ;

  // exception_i bit positions
  localparam int EX_MRET      = 0;
  localparam int EX_ECALL     = 1;
  localparam int EX_EBREAK    = 2;
  localparam int EX_MIS_INST  = 3;
  localparam int EX_ILLEGAL   = 4;
  localparam int EX_MIS_STORE = 5;
  localparam int EX_MIS_LOAD  = 6;

  typedef enum logic [2:0] {
    S_RESET,
    S_RUN,
    S_DRAIN,
    S_TRAP,
    S_MRET
  } state_t;

  state_t          state_reg;
  logic [XLEN-1:0] cause_reg;
  logic [XLEN-1:0] epc_reg;
  logic [XLEN-1:0] mtval_reg;
  logic [XLEN-1:0] new_pc_reg;
  logic            flush_reg;
  logic            csr_we_reg;
  logic            mie_clear_reg;
  logic            mie_set_reg;
  logic            mret_pend_reg;

  logic [NIRQ-1:0] ip;
  logic            irq_hit;
  logic [4:0]      irq_code;
  logic            exc_hit;
  logic [4:0]      exc_code;
  logic [XLEN-1:0] exc_tval;
  logic            trap_hit;
  logic [XLEN-1:0] trap_cause;
  logic [XLEN-1:0] trap_tval;
  logic            stall_any;
  logic            unused_ip;

  assign ip        = irq_en_i & irq_pend_i & {NIRQ{mstatus_mie_i}};
  assign stall_any = |stallreq_i;
  // Only MEI/MSI/MTI and the local lines can trap; the other mip bits are ignored.
  assign unused_ip = ^{ip[15:12], ip[10:8], ip[6:4], ip[2:0]};

  // Thermometer stall: the highest requesting stage stalls itself and everything older.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_STAGES; gi++) begin : g_stall
      assign stall_o[gi] = ~rst_i & (|stallreq_i[NUM_STAGES-1:gi]);
    end
  endgenerate

  // Redirect target: vectored mode offsets interrupts by 4*code, everything else goes to base.
  function automatic logic [XLEN-1:0] vector_pc(input logic [XLEN-1:0] tvec,
                                                input logic            is_irq,
                                                input logic [4:0]      code);
    logic [XLEN-1:0] base;
    base = {tvec[XLEN-1:2], 2'b00};
    if (tvec[1:0] == 2'b01 && is_irq) begin
      return base + XLEN'({code, 2'b00});
    end
    return base;
  endfunction

  // Interrupt arbitration: later assignments win, so list lowest priority first.
  always_comb begin
    irq_hit  = 1'b0;
    irq_code = 5'd0;
    for (int k = 0; k < NUM_LIRQ; k++) begin
      if (ip[16+k]) begin
        irq_hit  = 1'b1;
        irq_code = 5'(16 + k);
      end
    end
    if (ip[7]) begin
      irq_hit  = 1'b1;
      irq_code = 5'd7;
    end
    if (ip[3]) begin
      irq_hit  = 1'b1;
      irq_code = 5'd3;
    end
    if (ip[11]) begin
      irq_hit  = 1'b1;
      irq_code = 5'd11;
    end
  end

  // Synchronous exception arbitration with the matching mtval source.
  always_comb begin
    exc_hit  = 1'b1;
    exc_code = 5'd0;
    exc_tval = '0;
    if (exception_i[EX_MIS_INST]) begin
      exc_code = 5'd0;
      exc_tval = pc_i;
    end else if (exception_i[EX_ILLEGAL]) begin
      exc_code = 5'd2;
      exc_tval = XLEN'(ins_i);
    end else if (exception_i[EX_EBREAK]) begin
      exc_code = 5'd3;
      exc_tval = pc_i;
    end else if (exception_i[EX_ECALL]) begin
      exc_code = 5'd11;
    end else if (exception_i[EX_MIS_LOAD]) begin
      exc_code = 5'd4;
      exc_tval = badaddr_i;
    end else if (exception_i[EX_MIS_STORE]) begin
      exc_code = 5'd6;
      exc_tval = badaddr_i;
    end else begin
      exc_hit = 1'b0;
    end
  end

  // Merge: any qualified interrupt beats any exception; interrupts carry mtval 0.
  always_comb begin
    trap_hit               = irq_hit | exc_hit;
    trap_cause             = '0;
    trap_cause[4:0]        = irq_hit ? irq_code : exc_code;
    trap_cause[XLEN-1]     = irq_hit;
    trap_tval              = irq_hit ? '0 : exc_tval;
  end

  // Control FSM: latch the trap in RUN, hold it through DRAIN, emit one redirect cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg     <= S_RESET;
      cause_reg     <= '0;
      epc_reg       <= '0;
      mtval_reg     <= '0;
      new_pc_reg    <= REBOOT_ADDR;
      flush_reg     <= 1'b1;
      csr_we_reg    <= 1'b0;
      mie_clear_reg <= 1'b0;
      mie_set_reg   <= 1'b0;
      mret_pend_reg <= 1'b0;
    end else begin
      flush_reg     <= 1'b0;
      csr_we_reg    <= 1'b0;
      mie_clear_reg <= 1'b0;
      mie_set_reg   <= 1'b0;
      case (state_reg)
        S_RESET, S_TRAP, S_MRET: state_reg <= S_RUN;
        S_RUN: begin
          if (trap_hit) begin
            cause_reg     <= trap_cause;
            epc_reg       <= pc_i;
            mtval_reg     <= trap_tval;
            mret_pend_reg <= 1'b0;
            if (stall_any) begin
              state_reg <= S_DRAIN;
            end else begin
              state_reg     <= S_TRAP;
              flush_reg     <= 1'b1;
              csr_we_reg    <= 1'b1;
              mie_clear_reg <= 1'b1;
              new_pc_reg    <= vector_pc(mtvec_i, trap_cause[XLEN-1], trap_cause[4:0]);
            end
          end else if (exception_i[EX_MRET]) begin
            mret_pend_reg <= 1'b1;
            if (stall_any) begin
              state_reg <= S_DRAIN;
            end else begin
              state_reg   <= S_MRET;
              flush_reg   <= 1'b1;
              mie_set_reg <= 1'b1;
              new_pc_reg  <= mepc_i;
            end
          end
        end
        S_DRAIN: begin
          if (!stall_any) begin
            flush_reg <= 1'b1;
            if (mret_pend_reg) begin
              state_reg   <= S_MRET;
              mie_set_reg <= 1'b1;
              new_pc_reg  <= mepc_i;
            end else begin
              state_reg     <= S_TRAP;
              csr_we_reg    <= 1'b1;
              mie_clear_reg <= 1'b1;
              new_pc_reg    <= vector_pc(mtvec_i, cause_reg[XLEN-1], cause_reg[4:0]);
            end
          end
        end
        default: state_reg <= S_RESET;
      endcase
    end
  end

  // Everything is held quiet while reset is asserted, even mid-redirect.
  assign flush_o     = flush_reg & ~rst_i;
  assign set_cause_o = csr_we_reg & ~rst_i;
  assign set_epc_o   = csr_we_reg & ~rst_i;
  assign set_mtval_o = csr_we_reg & ~rst_i;
  assign mie_clear_o = mie_clear_reg & ~rst_i;
  assign mie_set_o   = mie_set_reg & ~rst_i;
  assign busy_o      = (state_reg != S_RUN) & ~rst_i;
  assign new_pc_o    = rst_i ? '0 : new_pc_reg;
  assign cause_o     = rst_i ? '0 : cause_reg;
  assign epc_o       = rst_i ? '0 : epc_reg;
  assign mtval_o     = rst_i ? '0 : mtval_reg;

endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: directed stimulus; a rule-level model checks every output each cycle,
// and literal expectations pin the model at the interesting points.
module tb_trap_ctrl;

  localparam int XLEN = 32;
  localparam int NS   = 6;
  localparam int NL   = 4;
  localparam logic [31:0] REBOOT = 32'h0000_0000;

  localparam logic [6:0] X_MRET  = 7'b0000001;
  localparam logic [6:0] X_ECALL = 7'b0000010;
  localparam logic [6:0] X_ILL   = 7'b0010000;
  localparam logic [6:0] X_LOAD  = 7'b1000000;

  logic            clk;
  logic            rst;
  logic [NS-1:0]   stallreq;
  logic [6:0]      exc;
  logic [31:0]     pc, ins, badaddr, mtvec, mepc;
  logic            mie;
  logic [19:0]     irq_en, irq_pend;
  logic [NS-1:0]   stall_o;
  logic            flush_o, set_cause_o, set_epc_o, set_mtval_o;
  logic [31:0]     new_pc_o, cause_o, epc_o, mtval_o;
  logic            mie_clear_o, mie_set_o, busy_o;

  int errors = 0;
  int checks = 0;

  trap_ctrl #(.XLEN(XLEN), .NUM_STAGES(NS), .NUM_LIRQ(NL), .REBOOT_ADDR(REBOOT)) dut (
    .clk_i(clk), .rst_i(rst), .stallreq_i(stallreq), .exception_i(exc), .pc_i(pc),
    .ins_i(ins), .badaddr_i(badaddr), .mstatus_mie_i(mie), .irq_en_i(irq_en),
    .irq_pend_i(irq_pend), .mtvec_i(mtvec), .mepc_i(mepc), .stall_o(stall_o),
    .flush_o(flush_o), .new_pc_o(new_pc_o), .set_cause_o(set_cause_o),
    .set_epc_o(set_epc_o), .set_mtval_o(set_mtval_o), .cause_o(cause_o), .epc_o(epc_o),
    .mtval_o(mtval_o), .mie_clear_o(mie_clear_o), .mie_set_o(mie_set_o), .busy_o(busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic        hit;
    logic [31:0] cause;
    logic [31:0] tval;
  } trap_t;

  // Walk the priority lists; first qualifying source wins.
  function automatic trap_t find_trap(input logic [19:0] en, input logic [19:0] pend,
                                      input logic m, input logic [6:0] x,
                                      input logic [31:0] p, input logic [31:0] iw,
                                      input logic [31:0] bad);
    trap_t t;
    int irq_order[7];
    int ebit[6];
    int ecode[6];
    logic [19:0] q;
    irq_order = '{11, 3, 7, 19, 18, 17, 16};
    ebit      = '{3, 4, 2, 1, 6, 5};
    ecode     = '{0, 2, 3, 11, 4, 6};
    t = '0;
    q = m ? (en & pend) : 20'd0;
    for (int i = 0; i < 7; i++) begin
      if (!t.hit && q[irq_order[i]]) begin
        t.hit   = 1'b1;
        t.cause = 32'h8000_0000 + 32'(irq_order[i]);
        t.tval  = 32'd0;
      end
    end
    for (int i = 0; i < 6; i++) begin
      if (!t.hit && x[ebit[i]]) begin
        t.hit   = 1'b1;
        t.cause = 32'(ecode[i]);
        case (ecode[i])
          0, 3:    t.tval = p;
          2:       t.tval = iw;
          4, 6:    t.tval = bad;
          default: t.tval = 32'd0;
        endcase
      end
    end
    return t;
  endfunction

  function automatic logic [31:0] exp_vec(input logic [31:0] tvec, input logic [31:0] cause);
    logic [31:0] base;
    base = tvec & 32'hFFFF_FFFC;
    if (tvec[1:0] == 2'b01 && cause[31]) return base + 32'd4 * (cause & 32'h7FFF_FFFF);
    return base;
  endfunction

  function automatic logic [31:0] exp_stall(input logic [NS-1:0] req);
    int h;
    h = -1;
    for (int k = 0; k < NS; k++) if (req[k]) h = k;
    if (h < 0) return 32'd0;
    return 32'((1 << (h + 1)) - 1);
  endfunction

  localparam int P_RUN = 0, P_WAIT = 1, P_TRAP = 2, P_MRET = 3, P_BOOT = 4;
  int          m_phase = P_BOOT;
  logic        m_mret = 1'b0;
  logic [31:0] m_cause = '0, m_epc = '0, m_mtval = '0, m_target = '0;
  trap_t       cur_t;

  always_comb cur_t = find_trap(irq_en, irq_pend, mie, exc, pc, ins, badaddr);

  // Model advance: what the next cycle must show, from this cycle's inputs.
  always @(posedge clk) begin
    if (rst) begin
      m_phase <= P_BOOT;
      m_cause <= '0;
      m_epc   <= '0;
      m_mtval <= '0;
    end else begin
      case (m_phase)
        P_RUN: begin
          if (cur_t.hit) begin
            m_cause <= cur_t.cause;
            m_epc   <= pc;
            m_mtval <= cur_t.tval;
            m_mret  <= 1'b0;
            if (stallreq == 0) begin
              m_phase  <= P_TRAP;
              m_target <= exp_vec(mtvec, cur_t.cause);
            end else m_phase <= P_WAIT;
          end else if (exc[0]) begin
            m_mret <= 1'b1;
            if (stallreq == 0) begin
              m_phase  <= P_MRET;
              m_target <= mepc;
            end else m_phase <= P_WAIT;
          end
        end
        P_WAIT: begin
          if (stallreq == 0) begin
            m_phase  <= m_mret ? P_MRET : P_TRAP;
            m_target <= m_mret ? mepc : exp_vec(mtvec, m_cause);
          end
        end
        default: m_phase <= P_RUN;
      endcase
    end
  end

  // Per-cycle comparison on the falling edge.
  always @(negedge clk) begin
    logic r, e_flush;
    r       = rst;
    e_flush = !r && (m_phase == P_BOOT || m_phase == P_TRAP || m_phase == P_MRET);
    chk("m_stall", 32'(stall_o), r ? 32'd0 : exp_stall(stallreq));
    chk("m_flush", 32'(flush_o), 32'(e_flush));
    chk("m_busy", 32'(busy_o), 32'(!r && m_phase != P_RUN));
    chk("m_set_cause", 32'(set_cause_o), 32'(!r && m_phase == P_TRAP));
    chk("m_set_epc", 32'(set_epc_o), 32'(!r && m_phase == P_TRAP));
    chk("m_set_mtval", 32'(set_mtval_o), 32'(!r && m_phase == P_TRAP));
    chk("m_mie_clear", 32'(mie_clear_o), 32'(!r && m_phase == P_TRAP));
    chk("m_mie_set", 32'(mie_set_o), 32'(!r && m_phase == P_MRET));
    chk("m_cause", cause_o, r ? 32'd0 : m_cause);
    chk("m_epc", epc_o, r ? 32'd0 : m_epc);
    chk("m_mtval", mtval_o, r ? 32'd0 : m_mtval);
    if (r) chk("m_new_pc_rst", new_pc_o, 32'd0);
    else if (e_flush) chk("m_new_pc", new_pc_o, (m_phase == P_BOOT) ? REBOOT : m_target);
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [6:0]  tx_exc[4]  = '{7'b0001100, 7'b0000110, 7'b0100000, 7'b1100000};
  logic [31:0] tx_cause[4] = '{32'd0, 32'd3, 32'd6, 32'd4};
  logic [31:0] tx_tval[4]  = '{32'h600, 32'h604, 32'h2002, 32'h2002};

  initial begin
    rst = 1'b1; stallreq = 6'b100001; exc = '0; pc = '0; ins = '0; badaddr = '0;
    mtvec = '0; mepc = '0; mie = 1'b0; irq_en = '0; irq_pend = '0;
    tick(); tick();
    $display("txn reset held");
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_flush", 32'(flush_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_new_pc", new_pc_o, 32'd0);
    stallreq = '0; rst = 1'b0; #1;
    $display("txn reset release");
    chk("boot_flush", 32'(flush_o), 32'd1);
    chk("boot_new_pc", new_pc_o, REBOOT);
    tick();
    chk("boot_done_flush", 32'(flush_o), 32'd0);
    chk("boot_done_busy", 32'(busy_o), 32'd0);

    $display("txn stall merge");
    stallreq = 6'b001000; #1; chk("stall_001000", 32'(stall_o), 32'h0F);
    stallreq = 6'b000000; #1; chk("stall_zero", 32'(stall_o), 32'h00);
    stallreq = 6'b100001; #1; chk("stall_100001", 32'(stall_o), 32'h3F);
    stallreq = '0;
    tick();

    $display("txn vectored MTI");
    mtvec = 32'h101; mie = 1'b1; irq_en = 20'h00080; irq_pend = 20'h00080;
    tick();
    chk("mti_flush", 32'(flush_o), 32'd1);
    chk("mti_new_pc", new_pc_o, 32'h11C);
    chk("mti_cause", cause_o, 32'h8000_0007);
    chk("mti_mie_clear", 32'(mie_clear_o), 32'd1);
    chk("mti_mtval", mtval_o, 32'd0);
    irq_pend = '0;
    tick();
    chk("mti_clear_1cyc", 32'(mie_clear_o), 32'd0);
    chk("mti_flush_1cyc", 32'(flush_o), 32'd0);

    $display("txn MTI mode 11 is direct");
    mtvec = 32'h103; irq_pend = 20'h00080;
    tick();
    chk("mode11_new_pc", new_pc_o, 32'h100);
    irq_pend = '0; mtvec = 32'h101;
    tick();

    $display("txn back-to-back MTI");
    irq_pend = 20'h00080;
    tick(); chk("b2b_first", 32'(flush_o), 32'd1);
    tick(); chk("b2b_gap", 32'(flush_o), 32'd0);
    tick(); chk("b2b_second", 32'(flush_o), 32'd1);
    irq_pend = '0;
    tick();

    $display("txn MEI + local2 + illegal");
    irq_en = 20'h40800; irq_pend = 20'h40800; exc = X_ILL; ins = 32'hFFFF_FFFF; pc = 32'h200;
    tick();
    chk("prio_cause", cause_o, 32'h8000_000B);
    chk("prio_mtval", mtval_o, 32'd0);
    chk("prio_new_pc", new_pc_o, 32'h12C);
    irq_en = '0; irq_pend = '0;
    tick();
    chk("prio_gap", 32'(flush_o), 32'd0);
    tick();
    $display("txn illegal alone");
    chk("ill_cause", cause_o, 32'd2);
    chk("ill_mtval", mtval_o, 32'hFFFF_FFFF);
    chk("ill_new_pc", new_pc_o, 32'h100);
    chk("ill_epc", epc_o, 32'h200);
    exc = '0;
    tick();

    $display("txn locals 1 and 3");
    irq_en = 20'hA0000; irq_pend = 20'hA0000;
    tick();
    chk("lirq_cause", cause_o, 32'h8000_0013);
    chk("lirq_new_pc", new_pc_o, 32'h14C);
    irq_pend = '0;
    tick();

    $display("txn MIE off with ecall");
    mie = 1'b0; irq_en = 20'h00800; irq_pend = 20'h00800; exc = X_ECALL; pc = 32'h500;
    tick();
    chk("ecall_cause", cause_o, 32'd11);
    chk("ecall_mtval", mtval_o, 32'd0);
    chk("ecall_epc", epc_o, 32'h500);
    exc = '0; irq_en = '0; irq_pend = '0; mie = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) begin
      $display("txn exception vector %0d exc=%b", i, tx_exc[i]);
      exc = tx_exc[i]; pc = 32'h600 + 32'(4 * i); badaddr = 32'h2002;
      tick();
      chk("exc_cause", cause_o, tx_cause[i]);
      chk("exc_mtval", mtval_o, tx_tval[i]);
      chk("exc_new_pc", new_pc_o, 32'h100);
      exc = '0;
      tick();
    end

    $display("txn drain misaligned load");
    exc = X_LOAD; badaddr = 32'h1003; pc = 32'h300; stallreq = 6'b001000;
    tick();
    chk("drain_busy", 32'(busy_o), 32'd1);
    chk("drain_flush0", 32'(flush_o), 32'd0);
    exc = X_ECALL; pc = 32'h999;
    tick();
    chk("drain_flush1", 32'(flush_o), 32'd0);
    exc = '0;
    tick();
    chk("drain_flush2", 32'(flush_o), 32'd0);
    stallreq = '0;
    tick();
    chk("drain_flush", 32'(flush_o), 32'd1);
    chk("drain_cause", cause_o, 32'd4);
    chk("drain_mtval", mtval_o, 32'h1003);
    chk("drain_epc", epc_o, 32'h300);
    tick();
    chk("drain_done", 32'(busy_o), 32'd0);

    $display("txn mret");
    mepc = 32'h8000_0040; exc = X_MRET;
    tick();
    chk("mret_flush", 32'(flush_o), 32'd1);
    chk("mret_new_pc", new_pc_o, 32'h8000_0040);
    chk("mret_mie_set", 32'(mie_set_o), 32'd1);
    chk("mret_no_cause", 32'(set_cause_o), 32'd0);
    exc = '0;
    tick();

    $display("txn stalled mret");
    exc = X_MRET; stallreq = 6'b000001;
    tick();
    chk("smret_wait", 32'(flush_o), 32'd0);
    exc = '0; stallreq = '0;
    tick();
    chk("smret_flush", 32'(flush_o), 32'd1);
    chk("smret_mie_set", 32'(mie_set_o), 32'd1);
    tick();

    $display("txn reset during drain");
    exc = X_ECALL; stallreq = 6'b000100;
    tick();
    exc = '0; rst = 1'b1; #1;
    chk("rdrain_busy", 32'(busy_o), 32'd0);
    tick();
    chk("rdrain_set", 32'(set_cause_o), 32'd0);
    stallreq = '0; rst = 1'b0; #1;
    chk("rdrain_boot", 32'(flush_o), 32'd1);
    chk("rdrain_boot_pc", new_pc_o, REBOOT);
    chk("rdrain_boot_set", 32'(set_cause_o), 32'd0);
    tick();

    $display("txn reset during trap");
    exc = X_ECALL; pc = 32'h400;
    tick();
    chk("rtrap_set_before", 32'(set_cause_o), 32'd1);
    exc = '0; rst = 1'b1; #1;
    chk("rtrap_set_gated", 32'(set_cause_o), 32'd0);
    chk("rtrap_flush_gated", 32'(flush_o), 32'd0);
    tick();
    rst = 1'b0; #1;
    chk("rtrap_boot", 32'(flush_o), 32'd1);
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
